// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle setup / tiling front end.
// Coordinates are signed 12.4 fixed point; tiles are 16x16 pixels on a 640x480 screen.
package raster_pkg;

    localparam int FX_INT_BITS  = 12;
    localparam int FX_FRAC_BITS = 4;
    localparam int COORD_W      = FX_INT_BITS + FX_FRAC_BITS;
    localparam int AREA_W       = 2 * (COORD_W + 1) + 1;

    localparam int TILE_WIDTH   = 16;
    localparam int TILE_COLUMNS = 40;
    localparam int TILE_ROWS    = 30;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [AREA_W-1:0]  area_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } coord_3d_t;

    typedef logic [5:0] tile_x_t;
    typedef logic [4:0] tile_y_t;

    typedef struct packed {
        coord_t min_x;
        coord_t max_x;
        coord_t min_y;
        coord_t max_y;
        area_t  area;
    } bbox_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BBOX,
        ST_SETUP,
        ST_EMIT
    } bin_state_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_bbox.sv
// Combinational triangle bounding box / signed area, plus the tile-space
// conversion, screen clamp and cull decision applied to a registered box.
module tri_bbox
    import raster_pkg::*;
#(
    parameter int COLS          = TILE_COLUMNS,
    parameter int ROWS          = TILE_ROWS,
    parameter int TILE_SHIFT    = 8,
    parameter int CULL_BACKFACE = 0
) (
    input  coord_t  v0x_i,
    input  coord_t  v0y_i,
    input  coord_t  v1x_i,
    input  coord_t  v1y_i,
    input  coord_t  v2x_i,
    input  coord_t  v2y_i,
    output bbox_t   bbox_o,
    input  bbox_t   bbox_i,
    output tile_x_t min_tx_o,
    output tile_x_t max_tx_o,
    output tile_y_t min_ty_o,
    output tile_y_t max_ty_o,
    output logic    cull_o
);

    localparam coord_t COL_LAST = coord_t'(COLS - 1);
    localparam coord_t ROW_LAST = coord_t'(ROWS - 1);

    logic signed [COORD_W:0]     e1x, e1y, e2x, e2y;
    logic signed [2*COORD_W+1:0] p_a, p_b;
    coord_t min_x, max_x, min_y, max_y;
    coord_t min_tx, max_tx, min_ty, max_ty;
    area_t  area;

    always_comb begin
        e1x = {v1x_i[COORD_W-1], v1x_i} - {v0x_i[COORD_W-1], v0x_i};
        e1y = {v1y_i[COORD_W-1], v1y_i} - {v0y_i[COORD_W-1], v0y_i};
        e2x = {v2x_i[COORD_W-1], v2x_i} - {v0x_i[COORD_W-1], v0x_i};
        e2y = {v2y_i[COORD_W-1], v2y_i} - {v0y_i[COORD_W-1], v0y_i};
        p_a = e1x * e2y;
        p_b = e2x * e1y;

        bbox_o.min_x = min3(v0x_i, v1x_i, v2x_i);
        bbox_o.max_x = max3(v0x_i, v1x_i, v2x_i);
        bbox_o.min_y = min3(v0y_i, v1y_i, v2y_i);
        bbox_o.max_y = max3(v0y_i, v1y_i, v2y_i);
        bbox_o.area  = {p_a[2*COORD_W+1], p_a} - {p_b[2*COORD_W+1], p_b};
    end

    // Arithmetic shift floors negative coordinates toward the tile left/above the screen.
    always_comb begin
        min_x  = bbox_i.min_x;
        max_x  = bbox_i.max_x;
        min_y  = bbox_i.min_y;
        max_y  = bbox_i.max_y;
        area   = bbox_i.area;
        min_tx = min_x >>> TILE_SHIFT;
        max_tx = max_x >>> TILE_SHIFT;
        min_ty = min_y >>> TILE_SHIFT;
        max_ty = max_y >>> TILE_SHIFT;

        cull_o = max_tx[COORD_W-1] || max_ty[COORD_W-1] ||
                 (min_tx > COL_LAST) || (min_ty > ROW_LAST) ||
                 (area == '0) || ((CULL_BACKFACE != 0) && area[AREA_W-1]);

        min_tx_o = min_tx[COORD_W-1]  ? '0 : min_tx[5:0];
        min_ty_o = min_ty[COORD_W-1]  ? '0 : min_ty[4:0];
        max_tx_o = (max_tx > COL_LAST) ? COL_LAST[5:0] : max_tx[5:0];
        max_ty_o = (max_ty > ROW_LAST) ? ROW_LAST[4:0] : max_ty[4:0];
    end

endmodule

// File: rtl/tri_binner.sv
// Accepts one triangle at a time, culls it or walks its clamped tile
// bounding box in raster order, one (triangle, tile) beat per handshake.
//   state | meaning
//   IDLE  | waiting for a triangle, rdy_out high
//   BBOX  | register per-axis min/max and signed area
//   SETUP | tile-convert, clamp, cull or load first tile
//   EMIT  | present beats until the last tile is taken
module tri_binner
    import raster_pkg::*;
#(
    parameter int SCREEN_W      = TILE_COLUMNS * TILE_WIDTH,
    parameter int SCREEN_H      = TILE_ROWS * TILE_WIDTH,
    parameter int TILE_W        = TILE_WIDTH,
    parameter int FRAC_BITS     = FX_FRAC_BITS,
    parameter int CULL_BACKFACE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_in,
    output logic        rdy_out,
    input  coord_3d_t   v0_in,
    input  coord_3d_t   v1_in,
    input  coord_3d_t   v2_in,
    input  logic [3:0]  color_in,
    input  logic        ready_in,
    output logic        vld_out,
    output coord_3d_t   v0_out,
    output coord_3d_t   v1_out,
    output coord_3d_t   v2_out,
    output logic [3:0]  color_out,
    output tile_x_t     tile_x_out,
    output tile_y_t     tile_y_out,
    output logic        last_out,
    output logic [15:0] culled_count
);

    bin_state_t  state_q, state_d;
    coord_3d_t   v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [3:0]  color_q, color_d;
    bbox_t       bbox_q, bbox_d, bbox_c;
    tile_x_t     min_tx_q, min_tx_d, max_tx_q, max_tx_d, tile_x_q, tile_x_d;
    tile_y_t     max_ty_q, max_ty_d, tile_y_q, tile_y_d;
    logic        vld_q, vld_d;
    logic [15:0] culled_q, culled_d;
    tile_x_t     min_tx_c, max_tx_c;
    tile_y_t     min_ty_c, max_ty_c;
    logic        cull_c;

    tri_bbox #(
        .COLS          (SCREEN_W / TILE_W),
        .ROWS          (SCREEN_H / TILE_W),
        .TILE_SHIFT    (FRAC_BITS + $clog2(TILE_W)),
        .CULL_BACKFACE (CULL_BACKFACE)
    ) u_bbox (
        .v0x_i    (v0_q.x),
        .v0y_i    (v0_q.y),
        .v1x_i    (v1_q.x),
        .v1y_i    (v1_q.y),
        .v2x_i    (v2_q.x),
        .v2y_i    (v2_q.y),
        .bbox_o   (bbox_c),
        .bbox_i   (bbox_q),
        .min_tx_o (min_tx_c),
        .max_tx_o (max_tx_c),
        .min_ty_o (min_ty_c),
        .max_ty_o (max_ty_c),
        .cull_o   (cull_c)
    );

    always_comb begin
        state_d  = state_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        color_d  = color_q;
        bbox_d   = bbox_q;
        min_tx_d = min_tx_q;
        max_tx_d = max_tx_q;
        max_ty_d = max_ty_q;
        tile_x_d = tile_x_q;
        tile_y_d = tile_y_q;
        vld_d    = vld_q;
        culled_d = culled_q;
        case (state_q)
            ST_IDLE: begin
                if (vld_in) begin
                    v0_d    = v0_in;
                    v1_d    = v1_in;
                    v2_d    = v2_in;
                    color_d = color_in;
                    state_d = ST_BBOX;
                end
            end
            ST_BBOX: begin
                bbox_d  = bbox_c;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cull_c) begin
                    if (culled_q != 16'hFFFF) culled_d = culled_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    min_tx_d = min_tx_c;
                    max_tx_d = max_tx_c;
                    max_ty_d = max_ty_c;
                    tile_x_d = min_tx_c;
                    tile_y_d = min_ty_c;
                    vld_d    = 1'b1;
                    state_d  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (vld_q && ready_in) begin
                    if (tile_x_q < max_tx_q) begin
                        tile_x_d = tile_x_q + 6'd1;
                    end else if (tile_y_q < max_ty_q) begin
                        tile_x_d = min_tx_q;
                        tile_y_d = tile_y_q + 5'd1;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            v0_q     <= '0;
            v1_q     <= '0;
            v2_q     <= '0;
            color_q  <= '0;
            bbox_q   <= '0;
            min_tx_q <= '0;
            max_tx_q <= '0;
            max_ty_q <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
            vld_q    <= 1'b0;
            culled_q <= '0;
        end else begin
            state_q  <= state_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            color_q  <= color_d;
            bbox_q   <= bbox_d;
            min_tx_q <= min_tx_d;
            max_tx_q <= max_tx_d;
            max_ty_q <= max_ty_d;
            tile_x_q <= tile_x_d;
            tile_y_q <= tile_y_d;
            vld_q    <= vld_d;
            culled_q <= culled_d;
        end
    end

    assign rdy_out      = (state_q == ST_IDLE) && rst_n;
    assign vld_out      = vld_q;
    assign v0_out       = v0_q;
    assign v1_out       = v1_q;
    assign v2_out       = v2_q;
    assign color_out    = color_q;
    assign tile_x_out   = tile_x_q;
    assign tile_y_out   = tile_y_q;
    assign last_out     = (tile_x_q == max_tx_q) && (tile_y_q == max_ty_q) && vld_q;
    assign culled_count = culled_q;

endmodule

// File: tb/tb_tri_binner.sv
// Bench for tri_binner: directed test-plan triangles plus random ones, each
// checked against an arithmetic tile-coverage model.
module tb_tri_binner;
    import raster_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, vld_in, rdy_out, ready_in, vld_out, last_out;
    coord_3d_t   v0_in, v1_in, v2_in, v0_out, v1_out, v2_out;
    logic [3:0]  color_in, color_out;
    tile_x_t     tile_x_out;
    tile_y_t     tile_y_out;
    logic [15:0] culled_count;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_culled = 0;

    typedef struct {
        int tx;
        int ty;
        bit last;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    tri_binner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_in       (vld_in),
        .rdy_out      (rdy_out),
        .v0_in        (v0_in),
        .v1_in        (v1_in),
        .v2_in        (v2_in),
        .color_in     (color_in),
        .ready_in     (ready_in),
        .vld_out      (vld_out),
        .v0_out       (v0_out),
        .v1_out       (v1_out),
        .v2_out       (v2_out),
        .color_out    (color_out),
        .tile_x_out   (tile_x_out),
        .tile_y_out   (tile_y_out),
        .last_out     (last_out),
        .culled_count (culled_count)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fdiv256(input int c);
        return (c >= 0) ? c / 256 : -((255 - c) / 256);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic coord_3d_t mk(input int x, input int y, input int z);
        coord_3d_t r;
        r.x = 16'(x);
        r.y = 16'(y);
        r.z = 16'(z);
        return r;
    endfunction

    function automatic coord_3d_t rnd_vtx();
        return coord_3d_t'({$urandom(), $urandom()});
    endfunction

    // Expected beats: every tile the clamped pixel bounding box touches, raster order.
    task automatic build_model(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2, output bit cull);
        longint area;
        int mnx, mxx, mny, mxy;
        area = longint'(x1 - x0) * longint'(y2 - y0) - longint'(x2 - x0) * longint'(y1 - y0);
        mnx  = fdiv256(imin(x0, imin(x1, x2)));
        mxx  = fdiv256(imax(x0, imax(x1, x2)));
        mny  = fdiv256(imin(y0, imin(y1, y2)));
        mxy  = fdiv256(imax(y0, imax(y1, y2)));
        exp_q.delete();
        cull = (area == 0) || (mxx < 0) || (mxy < 0) || (mnx > 39) || (mny > 29);
        if (!cull) begin
            mnx = imax(mnx, 0);
            mny = imax(mny, 0);
            mxx = imin(mxx, 39);
            mxy = imin(mxy, 29);
            for (int ty = mny; ty <= mxy; ty++)
                for (int tx = mnx; tx <= mxx; tx++)
                    exp_q.push_back('{tx, ty, (tx == mxx) && (ty == mxy)});
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles on beat 1, 3: reset on beat 2
    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int mode);
        bit            cull;
        int            guard, idx, hold;
        coord_3d_t     a, b, c;
        logic [3:0]    col;
        logic [147:0]  vtx;
        beat_t         e;
        build_model(x0, y0, x1, y1, x2, y2, cull);
        guard = 0;
        while (!rdy_out && guard < 20) begin
            step();
            guard++;
        end
        chk("rdy_before_accept", rdy_out, 1'b1);
        a   = mk(x0, y0, int'($urandom_range(0, 65535)));
        b   = mk(x1, y1, int'($urandom_range(0, 65535)));
        c   = mk(x2, y2, int'($urandom_range(0, 65535)));
        col = 4'($urandom_range(0, 15));
        vtx = {a, b, c, col};
        v0_in = a; v1_in = b; v2_in = c; color_in = col;
        vld_in = 1'b1;
        step();
        v0_in = rnd_vtx(); v1_in = rnd_vtx(); v2_in = rnd_vtx(); color_in = 4'($urandom);
        chk("rdy_low_after_accept", rdy_out, 1'b0);
        chk("no_beat_in_bbox", vld_out, 1'b0);
        step();
        chk("no_beat_in_setup", vld_out, 1'b0);
        step();
        vld_in = 1'b0;
        if (cull) begin
            if (exp_culled < 65535) exp_culled++;
            chk("cull_no_beat", vld_out, 1'b0);
            chk("cull_rdy_back", rdy_out, 1'b1);
            chk("cull_count", culled_count, exp_culled);
            return;
        end
        chk("first_beat_latency", vld_out, 1'b1);
        vld_in = 1'b1;
        idx = 0; hold = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            guard++;
            e = exp_q[0];
            chk("beat_valid", vld_out, 1'b1);
            chk("beat_tile", {tile_x_out, tile_y_out, last_out}, {6'(e.tx), 5'(e.ty), e.last});
            chk("beat_payload", {v0_out, v1_out, v2_out, color_out}, vtx);
            if (mode == 3 && idx == 2) begin
                vld_in = 1'b0;
                rst_n  = 1'b0;
                step();
                chk("rst_drops_beat", vld_out, 1'b0);
                chk("rst_clears_count", culled_count, 16'd0);
                chk("rst_clears_last", last_out, 1'b0);
                rst_n = 1'b1;
                exp_culled = 0;
                exp_q.delete();
                #1;
                chk("rdy_after_release", rdy_out, 1'b1);
                return;
            end
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = ($urandom_range(0, 3) != 0);
                2: begin
                    if (idx == 1 && hold < 5) begin
                        ready_in = 1'b0;
                        hold++;
                    end else ready_in = 1'b1;
                end
                default: ready_in = 1'b1;
            endcase
            if (ready_in && exp_q.size() == 1) vld_in = 1'b0;
            step();
            if (ready_in) begin
                void'(exp_q.pop_front());
                idx++;
            end
        end
        vld_in = 1'b0;
        chk("all_beats_seen", exp_q.size(), 0);
        chk("vld_drops_after_last", vld_out, 1'b0);
        chk("rdy_after_last", rdy_out, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x0, y0, x1, y1, x2, y2;
        rst_n = 1'b0; vld_in = 1'b1; ready_in = 1'b0;
        v0_in = '0; v1_in = '0; v2_in = '0; color_in = '0;
        step(); step(); step();
        chk("rst_rdy_low", rdy_out, 1'b0);
        chk("rst_vld", vld_out, 1'b0);
        chk("rst_last", last_out, 1'b0);
        chk("rst_tiles", {tile_x_out, tile_y_out}, 11'd0);
        chk("rst_culled", culled_count, 16'd0);
        chk("rst_payload", {v0_out, v1_out, v2_out, color_out}, 148'd0);
        vld_in = 1'b0;
        rst_n  = 1'b1;
        step();

        run_tri(256, 256, 400, 256, 256, 400, 0);
        run_tri(160, 160, 640, 160, 160, 640, 0);
        run_tri(160, 160, 640, 160, 160, 640, 2);
        run_tri(-160, 0, -160, 500, -160, 900, 0);
        run_tri(0, 0, 160, 160, 320, 320, 0);
        chk("cull_count_two", culled_count, 16'd2);
        run_tri(9600, 7200, 11200, 7200, 11200, 8000, 1);
        run_tri(10240, 100, 10000, 900, 9800, 100, 0);
        run_tri(160, 160, 640, 160, 160, 640, 3);
        run_tri(256, 256, 400, 256, 256, 400, 1);

        for (int i = 0; i < 30; i++) begin
            x0 = int'($urandom_range(0, 11000)) - 500;
            y0 = int'($urandom_range(0, 8400)) - 500;
            x1 = x0 + int'($urandom_range(0, 1600)) - 800;
            y1 = y0 + int'($urandom_range(0, 1600)) - 800;
            x2 = x0 + int'($urandom_range(0, 1600)) - 800;
            y2 = y0 + int'($urandom_range(0, 1600)) - 800;
            if (i % 7 == 0) begin
                x2 = 2 * x1 - x0;
                y2 = 2 * y1 - y0;
            end
            run_tri(x0, y0, x1, y1, x2, y2, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
